// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - measures a divided clock in the clk domain and checks it against an expected ratio
module div_clk_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_err,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_ratio,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             err_mismatch,
    output logic             err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACQ,
        S_LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   CNT_MAX_X = {1'b0, CNT_MAX};
    localparam logic [3:0]       LOCK_N    = 4'(LOCK_COUNT);

    state_t           state, state_n;
    logic             meta, s, s_d, rise;
    logic [CNT_W-1:0] ratio, cyc, hi, period_calc;
    logic [CNT_W:0]   cyc_p1, ratio_x2, t_thr;
    logic [3:0]       match, match_n;
    logic             ratio_ok, tmo, meas, match_ok, mismatch_set;

    assign rise        = s & ~s_d;
    assign cyc_p1      = {1'b0, cyc} + (CNT_W+1)'(1);
    assign period_calc = (cyc_p1 > CNT_MAX_X) ? CNT_MAX : cyc_p1[CNT_W-1:0];
    assign ratio_x2    = {ratio, 1'b0};
    assign t_thr       = (ratio_x2 > CNT_MAX_X) ? CNT_MAX_X : ratio_x2;
    assign ratio_ok    = (ratio > CNT_W'(1));

    // A rise on the threshold cycle takes priority over the timeout.
    assign tmo      = en && (state != S_IDLE) && ratio_ok && !rise && ({1'b0, cyc} >= t_thr);
    assign meas     = en && rise && ((state == S_ACQ) || (state == S_LOCKED));
    assign match_ok = ratio_ok && (period_calc == ratio);
    assign locked   = (state == S_LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        match_n      = match;
        mismatch_set = 1'b0;
        if (!en) begin
            state_n = S_IDLE;
            match_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_WAIT;
                    match_n = '0;
                end
                S_WAIT: begin
                    if (rise) begin
                        state_n = S_ACQ;
                        match_n = '0;
                    end
                end
                S_ACQ: begin
                    if (tmo) begin
                        state_n = S_WAIT;
                        match_n = '0;
                    end else if (meas) begin
                        if (match_ok) begin
                            match_n = match + 4'd1;
                            if (match_n == LOCK_N) state_n = S_LOCKED;
                        end else begin
                            match_n = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (tmo) begin
                        state_n = S_WAIT;
                        match_n = '0;
                    end else if (meas && !match_ok) begin
                        state_n      = S_ACQ;
                        match_n      = '0;
                        mismatch_set = 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    match_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta         <= 1'b0;
            s            <= 1'b0;
            s_d          <= 1'b0;
            ratio        <= '0;
            cyc          <= '0;
            hi           <= '0;
            match        <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            meta  <= div_in;
            s     <= meta;
            s_d   <= s;
            match <= match_n;
            if (state == S_IDLE && en) ratio <= exp_ratio;

            if (!en || state == S_IDLE || rise || tmo) cyc <= '0;
            else if (cyc != CNT_MAX)                   cyc <= cyc + CNT_W'(1);

            // The rise cycle itself counts as the first high cycle.
            if (rise)                      hi <= CNT_W'(1);
            else if (s && hi != CNT_MAX)   hi <= hi + CNT_W'(1);

            period_valid <= meas;
            if (meas) begin
                period    <= period_calc;
                high_time <= hi;
            end

            err_timeout  <= tmo | (err_timeout & ~clr_err);
            err_mismatch <= mismatch_set | (err_mismatch & ~clr_err);
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - directed self-checking bench for div_clk_monitor
module tb_div_clk_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr_err = 1'b0;
    logic       div_in = 1'b0;
    logic [7:0] exp_ratio = 8'd2;
    logic [7:0] period, high_time;
    logic       period_valid, locked, err_mismatch, err_timeout;

    int n_checks = 0;
    int n_pass = 0;
    int step_cnt, pv_cnt, first_pv_step, last_pv_step, pv_gap, lock_at, lock_with_pv;
    int last_period, last_high;
    bit lock_seen;

    div_clk_monitor #(.CNT_W(8), .LOCK_COUNT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .div_in(div_in),
        .exp_ratio(exp_ratio), .period(period), .high_time(high_time),
        .period_valid(period_valid), .locked(locked),
        .err_mismatch(err_mismatch), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic mark();
        step_cnt = 0; pv_cnt = 0; first_pv_step = -1; last_pv_step = -1; pv_gap = -1;
        lock_at = -1; lock_with_pv = 0; lock_seen = 0; last_period = -1; last_high = -1;
    endtask

    task automatic step(input logic d);
        div_in = d;
        @(posedge clk);
        #1;
        step_cnt++;
        if (period_valid) begin
            pv_cnt++;
            if (first_pv_step < 0) first_pv_step = step_cnt;
            if (last_pv_step >= 0) pv_gap = step_cnt - last_pv_step;
            last_pv_step = step_cnt;
            last_period = int'(period);
            last_high = int'(high_time);
        end
        if (locked && !lock_seen) begin
            lock_seen = 1;
            lock_at = pv_cnt;
            lock_with_pv = int'(period_valid);
        end
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            repeat (h) step(1'b1);
            repeat (l) step(1'b0);
        end
    endtask

    initial begin
        mark();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_period", int'(period), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_errs", int'({err_mismatch, err_timeout}), 0);

        // divide-by-2, ratio 2
        rst = 1'b1; exp_ratio = 8'd2; en = 1'b1;
        mark();
        wave(1, 1, 8);
        step(1'b0); step(1'b0);
        chk("div2_pv_count", pv_cnt, 7);
        chk("div2_period", last_period, 2);
        chk("div2_high", last_high, 1);
        chk("div2_gap", pv_gap, 2);
        chk("div2_lock_at", lock_at, 4);
        chk("div2_lock_with_pv", lock_with_pv, 1);
        chk("div2_locked", int'(locked), 1);
        chk("div2_no_errs", int'({err_mismatch, err_timeout}), 0);

        // asynchronous reset mid-period
        step(1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_high", int'(high_time), 0);
        chk("arst_locked", int'(locked), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        mark();
        wave(1, 1, 4);
        chk("arst_first_pv_step", first_pv_step, 5);
        chk("arst_pv_count", pv_cnt, 2);

        // divide-by-3, ratio 3, then a stretched period
        en = 1'b0;
        step(1'b0); step(1'b0);
        exp_ratio = 8'd3; en = 1'b1;
        mark();
        wave(1, 2, 6);
        chk("div3_lock_at", lock_at, 4);
        chk("div3_period", last_period, 3);
        chk("div3_high", last_high, 1);
        chk("div3_locked", int'(locked), 1);
        wave(1, 3, 1);
        wave(1, 2, 1);
        chk("stretch_period", last_period, 4);
        chk("stretch_mismatch", int'(err_mismatch), 1);
        chk("stretch_unlocked", int'(locked), 0);
        mark();
        wave(1, 2, 4);
        chk("relock_pv", pv_cnt, 4);
        chk("relock_locked", int'(locked), 1);
        chk("relock_sticky", int'(err_mismatch), 1);
        clr_err = 1'b1;
        step(1'b1);
        clr_err = 1'b0;
        step(1'b0); step(1'b0);
        chk("clr_mismatch", int'(err_mismatch), 0);
        chk("clr_still_locked", int'(locked), 1);

        // stuck low -> timeout at T = 6
        repeat (6) step(1'b0);
        chk("tmo_not_yet", int'(err_timeout), 0);
        step(1'b0);
        chk("tmo_fired", int'(err_timeout), 1);
        chk("tmo_unlocked", int'(locked), 0);
        mark();
        wave(1, 2, 3);
        chk("tmo_resume_pv", pv_cnt, 2);
        chk("tmo_resume_period", last_period, 3);

        // enable drop during ACQ
        en = 1'b0;
        mark();
        wave(1, 2, 2);
        chk("endrop_pv", pv_cnt, 0);
        chk("endrop_locked", int'(locked), 0);
        chk("endrop_tmo_kept", int'(err_timeout), 1);
        chk("endrop_period_hold", int'(period), 3);

        // exp_ratio change ignored while enabled
        en = 1'b1;
        mark();
        wave(1, 2, 6);
        chk("ratio3_locked", int'(locked), 1);
        exp_ratio = 8'd5;
        wave(1, 4, 2);
        chk("ratio_ign_period", last_period, 5);
        chk("ratio_ign_mismatch", int'(err_mismatch), 1);
        chk("ratio_ign_unlocked", int'(locked), 0);
        en = 1'b0;
        step(1'b0); step(1'b0);
        en = 1'b1;
        mark();
        wave(1, 4, 6);
        chk("ratio5_lock_at", lock_at, 4);
        chk("ratio5_locked", int'(locked), 1);

        // ratio 1: report but never lock, no timeout, saturated period
        en = 1'b0;
        step(1'b0); step(1'b0);
        exp_ratio = 8'd1; clr_err = 1'b1;
        step(1'b0);
        clr_err = 1'b0; en = 1'b1;
        mark();
        wave(1, 1, 8);
        step(1'b0); step(1'b0);
        chk("r1_pv_count", pv_cnt, 7);
        chk("r1_period", last_period, 2);
        chk("r1_never_locked", int'(lock_seen), 0);
        repeat (300) step(1'b0);
        chk("r1_no_timeout", int'(err_timeout), 0);
        chk("r1_no_pv_idle", pv_cnt, 7);
        step(1'b1); step(1'b0); step(1'b0);
        chk("r1_sat_period", last_period, 255);
        chk("r1_sat_high", last_high, 1);
        chk("r1_no_mismatch", int'(err_mismatch), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
